uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive front end for the Amber UART. Synchronises the asynchronous `i_uart_rxd` pin and recovers 8N1 frames by mid-bit sampling, using a parameterised bit-period counter. Each received byte is presented as a single-cycle strobe, which writes it into the UART RX FIFO. Framing, break and overrun conditions are flagged as single-cycle pulses that feed the UART receive status register (RSR).

## Interface
- `CLKS_PER_BIT`, default 347: `i_clk` cycles per serial bit (40 MHz / 115200). Legal range is 4..65535. `HALF = CLKS_PER_BIT/2`, using integer division.
- `i_clk` in 1: system clock. This is the only clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_enable` in 1: receiver enable, from the UART CR RXE bit.
- `i_uart_rxd` in 1: serial input. Asynchronous to `i_clk`; idles high.
- `i_rx_full` in 1: RX FIFO full, from the downstream UART.
- `o_rx_byte` out 8: last received byte. Holds its value between frames.
- `o_rx_valid` out 1: one-cycle push strobe; `o_rx_byte` is valid in the same cycle.
- `o_framing_err` out 1: one-cycle pulse; the stop bit was sampled low.
- `o_break` out 1: one-cycle pulse; framing error with data byte 0x00.
- `o_overrun_err` out 1: one-cycle pulse; a good frame was dropped because `i_rx_full` was high.
- `o_busy` out 1: high whenever state is not IDLE.
- `o_state` out 4: current state encoding, for debug and formal checks.

## Operation
- **Synchroniser and edge detect**
  - Two-flop synchroniser on `i_uart_rxd` produces `s2`.
  - A delayed copy `s2_d` is kept. All three flops reset to 1.
  - A falling edge is `s2_d==1 && s2==0`.
- **Bit counter**
  - Counter `cnt` is 16 bits.
  - It clears on every state change and increments every cycle otherwise.
- **States** (encoding in brackets):
  - IDLE (0)
  - START (1)
  - DATA0..DATA7 (2..9)
  - STOP (10)
  - WAIT_HIGH (11)
- **Transitions**
  - IDLE → START: on a falling edge while `i_enable` is high.
  - START, at `cnt==HALF-1`, samples `s2`:
    - 0 → DATA0.
    - 1 → IDLE. This is a false start: no flag, no output.
  - DATAn, at `cnt==CLKS_PER_BIT-1`:
    - Shift `s2` into the shift register, LSB first: `sr <= {s2, sr[7:1]}`.
    - Go to DATAn+1; DATA7 goes to STOP.
  - STOP, at `cnt==CLKS_PER_BIT-1`, samples `s2`:
    - 1 and `i_rx_full==0`: `o_rx_byte<=sr`, pulse `o_rx_valid`, go to IDLE.
    - 1 and `i_rx_full==1`: pulse `o_overrun_err`; `o_rx_byte` is unchanged; go to IDLE.
    - 0: pulse `o_framing_err`, and also pulse `o_break` if `sr==0`. Go to WAIT_HIGH.
  - WAIT_HIGH → IDLE: when `s2==1`. No start detection happens while in WAIT_HIGH.
- **Disable**
  - `i_enable` low in any state forces IDLE on the next edge and clears `cnt`.
  - No pulse is produced for the aborted frame.
  - `o_rx_byte` is held.
- **Counter range**
  - `cnt` never exceeds `CLKS_PER_BIT-1`.
- **Pulse exclusivity**
  - Status pulses are mutually exclusive, except that `o_break` implies `o_framing_err` in the same cycle.

## Timing
- **Reset values**
  - Outputs: `o_rx_byte`=0x00; `o_rx_valid`, `o_framing_err`, `o_break`, `o_overrun_err`, `o_busy` = 0; `o_state`=0.
  - Internal: shift register 0x00; `cnt`=0.
- **Reset mid-frame**
  - Reset is asynchronous and immediate.
  - Nothing is emitted for the partial frame.
- **Start detection latency**
  - Let `i_uart_rxd` first be sampled low at edge k.
  - The state is START from the cycle after edge k+2; call this cycle T, with `cnt`=0.
- **Sample points, relative to T**
  - Start bit: T+HALF-1.
  - DATAn: T+HALF+(n+1)·CLKS_PER_BIT-1.
  - Stop bit: T+HALF+9·CLKS_PER_BIT-1.
- **Output timing**
  - `o_rx_valid` and the status pulses are registered.
  - They are high during cycle T+HALF+9·CLKS_PER_BIT, for exactly one cycle.
- **Back-to-back frames**
  - IDLE is re-entered in the same cycle as the valid pulse.
  - A start edge arriving ≥HALF cycles after the stop-bit centre is detected, so continuous 8N1 traffic has zero gap loss.
- **`i_rx_full`**
  - Sampled only at the stop-bit sample cycle.

## Test plan
- **Single byte:** `CLKS_PER_BIT`=16; send 0x55 as 8N1 → `o_rx_valid` for 1 cycle at T+152 with `o_rx_byte`=0x55. `o_busy` is 0 from T+152 onward.
- **Back-to-back:** 0xA3, 0x00, 0xFF with no idle gap → three valid pulses, 160 cycles apart, in order. No error flags.
- **False start:** 4-cycle low glitch, then line high → return to IDLE at T+8. No pulses; `o_rx_byte` unchanged.
- **Framing and break:**
  - 0xA3 with stop bit low → `o_framing_err` pulse, no valid, state 11 until the line rises.
  - Line held low for 300 cycles → `o_framing_err` and `o_break` in the same cycle.
- **Overrun:** `i_rx_full`=1 across the stop sample of 0x3C → `o_overrun_err` pulse, no valid, `o_rx_byte` keeps its previous value.
- **Abort:**
  - `i_enable` dropped during DATA4 → IDLE next cycle, no pulses.
  - `i_rst` asserted during DATA2 → all outputs at reset values immediately.
  - Next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// Receive front end for the Amber UART: synchronises the serial pin, recovers
// 8N1 frames by mid-bit sampling and emits one-cycle push and status pulses.

module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_uart_rxd,
  input  logic       i_rx_full,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_framing_err,
  output logic       o_break,
  output logic       o_overrun_err,
  output logic       o_busy,
  output logic [3:0] o_state
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [15:0] C_HALF_M1 = 16'(HALF - 1);
  localparam logic [15:0] C_BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_DATA0     = 4'd2,
    ST_DATA1     = 4'd3,
    ST_DATA2     = 4'd4,
    ST_DATA3     = 4'd5,
    ST_DATA4     = 4'd6,
    ST_DATA5     = 4'd7,
    ST_DATA6     = 4'd8,
    ST_DATA7     = 4'd9,
    ST_STOP      = 4'd10,
    ST_WAIT_HIGH = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_s2;
  logic        r_s2_d;
  logic [15:0] r_cnt;
  logic [7:0]  r_sr;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid;
  logic        r_framing_err;
  logic        r_break;
  logic        r_overrun_err;

  logic        w_fall;
  logic        w_half_done;
  logic        w_bit_done;
  logic        w_in_data;
  logic        w_shift;
  logic        w_push;
  logic        w_overrun;
  logic        w_framing;
  logic        w_break;

  assign w_fall      = r_s2_d & ~r_s2;
  assign w_half_done = (r_cnt == C_HALF_M1);
  assign w_bit_done  = (r_cnt == C_BIT_M1);
  assign w_in_data   = (r_state >= ST_DATA0) && (r_state <= ST_DATA7);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  // Reset to 1 so a reset line does not look like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_s2    <= 1'b1;
      r_s2_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a shift chain.
      r_sync1 <= i_uart_rxd;
      r_s2    <= r_sync1;
      r_s2_d  <= r_s2;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bit-period counter: restarts on every state change and stays at zero in
  // the states that do not time anything, so it never passes CLKS_PER_BIT-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state || r_state == ST_IDLE ||
                 r_state == ST_WAIT_HIGH) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Next-state logic; a low enable overrides everything and aborts the frame.
  always_comb begin
    // NOTE: defaulting to the current state first keeps every path assigned,
    // so no latch is inferred for the cases that do not move.
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_fall) w_state_nxt = ST_START;
        ST_START:     if (w_half_done) w_state_nxt = r_s2 ? ST_IDLE : ST_DATA0;
        ST_DATA0:     if (w_bit_done) w_state_nxt = ST_DATA1;
        ST_DATA1:     if (w_bit_done) w_state_nxt = ST_DATA2;
        ST_DATA2:     if (w_bit_done) w_state_nxt = ST_DATA3;
        ST_DATA3:     if (w_bit_done) w_state_nxt = ST_DATA4;
        ST_DATA4:     if (w_bit_done) w_state_nxt = ST_DATA5;
        ST_DATA5:     if (w_bit_done) w_state_nxt = ST_DATA6;
        ST_DATA6:     if (w_bit_done) w_state_nxt = ST_DATA7;
        ST_DATA7:     if (w_bit_done) w_state_nxt = ST_STOP;
        ST_STOP:      if (w_bit_done) w_state_nxt = r_s2 ? ST_IDLE : ST_WAIT_HIGH;
        ST_WAIT_HIGH: if (r_s2) w_state_nxt = ST_IDLE;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode: which sample-point actions fire this cycle.
  always_comb begin
    w_shift   = 1'b0;
    w_push    = 1'b0;
    w_overrun = 1'b0;
    w_framing = 1'b0;
    w_break   = 1'b0;
    if (i_enable) begin
      w_shift = w_in_data && w_bit_done;
      if (r_state == ST_STOP && w_bit_done) begin
        w_push    = r_s2 & ~i_rx_full;
        w_overrun = r_s2 &  i_rx_full;
        w_framing = ~r_s2;
        w_break   = ~r_s2 && (r_sr == 8'h00);
      end
    end
  end

  // Data path and registered status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr          <= 8'h00;
      r_rx_byte     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_framing_err <= 1'b0;
      r_break       <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_shift) r_sr      <= {r_s2, r_sr[7:1]};
      if (w_push)  r_rx_byte <= r_sr;
      r_rx_valid    <= w_push;
      r_framing_err <= w_framing;
      r_break       <= w_break;
      r_overrun_err <= w_overrun;
    end
  end

  assign o_rx_byte     = r_rx_byte;
  assign o_rx_valid    = r_rx_valid;
  assign o_framing_err = r_framing_err;
  assign o_break       = r_break;
  assign o_overrun_err = r_overrun_err;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_state       = r_state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
// Directed bench for uart_rx_deserializer with CLKS_PER_BIT = 16 (HALF = 8).
// Inputs change on the falling clock edge; outputs are observed there too.
// A line change driven at the falling edge where cyc == c is first sampled
// at rising edge c+1, so T is cycle c+3 and the stop-bit pulse is seen when
// cyc == c+3+152 = c+155.

module tb_uart_rx_deserializer;

  localparam int CPB = 16;

  logic       i_clk;
  logic       i_rst;
  logic       i_enable;
  logic       i_uart_rxd;
  logic       i_rx_full;
  logic [7:0] o_rx_byte;
  logic       o_rx_valid;
  logic       o_framing_err;
  logic       o_break;
  logic       o_overrun_err;
  logic       o_busy;
  logic [3:0] o_state;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_uart_rxd   (i_uart_rxd),
    .i_rx_full    (i_rx_full),
    .o_rx_byte    (o_rx_byte),
    .o_rx_valid   (o_rx_valid),
    .o_framing_err(o_framing_err),
    .o_break      (o_break),
    .o_overrun_err(o_overrun_err),
    .o_busy       (o_busy),
    .o_state      (o_state)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles of every strobe and logs valid pushes.
  int         n_valid = 0, n_fe = 0, n_brk = 0, n_ovr = 0;
  int         last_fe_cyc = -1, last_brk_cyc = -1, last_ovr_cyc = -1;
  int         v_cyc[$];
  logic [7:0] v_byte[$];

  always @(negedge i_clk) begin
    if (o_rx_valid) begin
      n_valid++;
      v_cyc.push_back(cyc);
      v_byte.push_back(o_rx_byte);
    end
    if (o_framing_err) begin n_fe++;  last_fe_cyc  = cyc; end
    if (o_break)       begin n_brk++; last_brk_cyc = cyc; end
    if (o_overrun_err) begin n_ovr++; last_ovr_cyc = cyc; end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drive_bit(input logic b);
    i_uart_rxd = b;
    wait_cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  int s_valid, s_fe, s_brk, s_ovr, c0;

  task automatic snap();
    s_valid = n_valid; s_fe = n_fe; s_brk = n_brk; s_ovr = n_ovr;
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_byte"},  32'(o_rx_byte),     32'h00);
    chk({tag, "_valid"}, 32'(o_rx_valid),    32'h0);
    chk({tag, "_fe"},    32'(o_framing_err), 32'h0);
    chk({tag, "_brk"},   32'(o_break),       32'h0);
    chk({tag, "_ovr"},   32'(o_overrun_err), 32'h0);
    chk({tag, "_busy"},  32'(o_busy),        32'h0);
    chk({tag, "_state"}, 32'(o_state),       32'h0);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_enable   = 1'b1;
    i_uart_rxd = 1'b1;
    i_rx_full  = 1'b0;
    wait_cyc(3);
    chk_outputs_reset("reset");
    i_rst = 1'b0;
    wait_cyc(10);

    // Single byte 0x55.
    snap();
    c0 = cyc;
    send_frame(8'h55, 1'b1);
    chk("single_nvalid", 32'(n_valid - s_valid), 1);
    chk("single_cyc",    32'(v_cyc[s_valid]), 32'(c0 + 155));
    chk("single_byte",   32'(v_byte[s_valid]), 32'h55);
    chk("single_noerr",  32'(n_fe + n_brk + n_ovr - s_fe - s_brk - s_ovr), 0);
    chk("single_busy",   32'(o_busy), 0);

    // Back-to-back 0xA3, 0x00, 0xFF with no idle gap.
    snap();
    c0 = cyc;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    chk("b2b_nvalid", 32'(n_valid - s_valid), 3);
    chk("b2b_cyc0",   32'(v_cyc[s_valid]),     32'(c0 + 155));
    chk("b2b_cyc1",   32'(v_cyc[s_valid + 1]), 32'(c0 + 315));
    chk("b2b_cyc2",   32'(v_cyc[s_valid + 2]), 32'(c0 + 475));
    chk("b2b_byte0",  32'(v_byte[s_valid]),     32'hA3);
    chk("b2b_byte1",  32'(v_byte[s_valid + 1]), 32'h00);
    chk("b2b_byte2",  32'(v_byte[s_valid + 2]), 32'hFF);
    chk("b2b_noerr",  32'(n_fe + n_brk + n_ovr - s_fe - s_brk - s_ovr), 0);
    wait_cyc(20);

    // False start: 4-cycle glitch; START during T..T+7, IDLE at T+8.
    snap();
    c0 = cyc;
    i_uart_rxd = 1'b0;
    wait_cyc(4);
    i_uart_rxd = 1'b1;
    wait_cyc(6);
    chk("false_start_state", 32'(o_state), 1);
    wait_cyc(1);
    chk("false_idle_state",  32'(o_state), 0);
    wait_cyc(20);
    chk("false_nopulse", 32'(n_valid + n_fe + n_brk + n_ovr - s_valid - s_fe - s_brk - s_ovr), 0);
    chk("false_byte",    32'(o_rx_byte), 32'hFF);

    // Framing error: 0xA3 with a low stop bit, line stays low.
    snap();
    c0 = cyc;
    send_frame(8'hA3, 1'b0);
    wait_cyc(20);
    chk("fe_count",  32'(n_fe - s_fe), 1);
    chk("fe_cyc",    32'(last_fe_cyc), 32'(c0 + 155));
    chk("fe_nobrk",  32'(n_brk - s_brk), 0);
    chk("fe_novalid", 32'(n_valid - s_valid), 0);
    chk("fe_wait_state", 32'(o_state), 11);
    i_uart_rxd = 1'b1;
    wait_cyc(4);
    chk("fe_idle_state", 32'(o_state), 0);
    wait_cyc(20);

    // Break: line low for 300 cycles.
    snap();
    c0 = cyc;
    i_uart_rxd = 1'b0;
    wait_cyc(300);
    i_uart_rxd = 1'b1;
    wait_cyc(20);
    chk("brk_fe_count",  32'(n_fe - s_fe), 1);
    chk("brk_count",     32'(n_brk - s_brk), 1);
    chk("brk_fe_cyc",    32'(last_fe_cyc), 32'(c0 + 155));
    chk("brk_cyc",       32'(last_brk_cyc), 32'(c0 + 155));
    chk("brk_novalid",   32'(n_valid - s_valid), 0);
    chk("brk_idle",      32'(o_state), 0);

    // Overrun: FIFO full across the stop sample of 0x3C.
    snap();
    c0 = cyc;
    i_rx_full = 1'b1;
    send_frame(8'h3C, 1'b1);
    i_rx_full = 1'b0;
    chk("ovr_count",   32'(n_ovr - s_ovr), 1);
    chk("ovr_cyc",     32'(last_ovr_cyc), 32'(c0 + 155));
    chk("ovr_novalid", 32'(n_valid - s_valid), 0);
    chk("ovr_nofe",    32'(n_fe - s_fe), 0);
    chk("ovr_byte",    32'(o_rx_byte), 32'hFF);
    wait_cyc(20);

    // Enable dropped during DATA4 (cycles c0+75..c0+90).
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_cyc(8);
    chk("abort_en_data4", 32'(o_state), 6);
    i_enable = 1'b0;
    wait_cyc(1);
    chk("abort_en_idle",  32'(o_state), 0);
    chk("abort_en_busy",  32'(o_busy), 0);
    wait_cyc(40);
    i_enable = 1'b1;
    wait_cyc(20);
    chk("abort_en_nopulse", 32'(n_valid + n_fe + n_brk + n_ovr - s_valid - s_fe - s_brk - s_ovr), 0);
    chk("abort_en_byte",    32'(o_rx_byte), 32'hFF);

    // Reset asserted during DATA2 (cycles c0+43..c0+58).
    snap();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    wait_cyc(2);
    chk("abort_rst_data2", 32'(o_state), 4);
    i_rst      = 1'b1;
    i_uart_rxd = 1'b1;
    #1;
    chk_outputs_reset("abort_rst");
    wait_cyc(1);
    i_rst = 1'b0;
    wait_cyc(20);
    chk("abort_rst_nopulse", 32'(n_valid + n_fe + n_brk + n_ovr - s_valid - s_fe - s_brk - s_ovr), 0);

    // Recovery frame 0x81.
    snap();
    c0 = cyc;
    send_frame(8'h81, 1'b1);
    chk("rec_nvalid", 32'(n_valid - s_valid), 1);
    chk("rec_cyc",    32'(v_cyc[s_valid]), 32'(c0 + 155));
    chk("rec_byte",   32'(v_byte[s_valid]), 32'h81);
    chk("rec_noerr",  32'(n_fe + n_brk + n_ovr - s_fe - s_brk - s_ovr), 0);
    wait_cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
